// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and default widths for the cache/pmem arbiter
//
// Purpose : FSM state and client enums plus the default address/line widths
//           used by cache_pmem_arbiter and arb_select.
// Ports   : none (package).
package arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        CLI_I = 1'b0,
        CLI_D = 1'b1
    } arb_client_e;

endpackage

// File: rtl/arb_select.sv
// rtl/arb_select.sv - combinational grant selection between I-cache and D-cache
//
// Purpose : picks which pending cache request is launched next.
//           Default build: D-cache has fixed priority over I-cache.
//           With ARB_ROUND_ROBIN_EN defined: on a tie the client that was not
//           granted last wins; a lone request is always granted.
// Ports   : i_req       in   I-cache request pending
//           d_req       in   D-cache request pending
//           last_grant  in   most recent grant (only used with ARB_ROUND_ROBIN_EN)
//           grant_valid out  at least one request pending
//           grant       out  selected client (meaningful when grant_valid)
module arb_select
    import arb_pkg::*;
(
    input  logic        i_req,
    input  logic        d_req,
    input  arb_client_e last_grant,
    output logic        grant_valid,
    output arb_client_e grant
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant       = CLI_D;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            grant = (last_grant == CLI_I) ? CLI_D : CLI_I;
        end else if (i_req) begin
            grant = CLI_I;
        end
`else
        if (!d_req) begin
            grant = CLI_I;
        end
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority never looks at the history input.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/cache_pmem_arbiter.sv
// rtl/cache_pmem_arbiter.sv - shares one pmem port between the I-cache and D-cache
//
// Purpose : serializes I-cache line reads and D-cache line reads/writebacks onto
//           a single physical-memory port, one transaction at a time, and routes
//           the response back to its owner as a 1-cycle resp pulse.
//           Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention
//           (last_grant flop); otherwise fixed D>I priority.
// Ports   : clk, rst (async, active-high)
//           i_pmem_read/address         in   I-cache request
//           i_pmem_resp/rdata           out  I-cache completion and line
//           d_pmem_read/write/address/wdata in D-cache request
//           d_pmem_resp/rdata           out  D-cache completion and line
//           pmem_read/write/address/wdata out memory request (registered)
//           pmem_resp/rdata             in   memory completion and line
module cache_pmem_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    arb_state_e        state_q, state_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
    logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
    logic              i_resp_q, i_resp_d;
    logic              d_resp_q, d_resp_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

    logic              d_req;
    logic              grant_valid;
    arb_client_e       grant;
    arb_client_e       last_grant;

    assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
    arb_client_e last_grant_q, last_grant_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= CLI_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = CLI_I;
`endif

    arb_select u_select (
        .i_req       (i_pmem_read),
        .d_req       (d_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            i_resp_q       <= 1'b0;
            d_resp_q       <= 1'b0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
        end else begin
            state_q        <= state_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            i_resp_q       <= i_resp_d;
            d_resp_q       <= d_resp_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
        // resp pulses only in the cycle right after the completing edge
        i_resp_d       = 1'b0;
        d_resp_d       = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d   = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant == CLI_D) begin
                        pmem_address_d = d_pmem_address;
                        pmem_wdata_d   = d_pmem_wdata;
                        // an illegal read+write request is treated as a writeback
                        pmem_read_d    = ~d_pmem_write;
                        pmem_write_d   = d_pmem_write;
                        state_d        = SERVE_D;
                    end else begin
                        pmem_address_d = i_pmem_address;
                        pmem_wdata_d   = '0;
                        pmem_read_d    = 1'b1;
                        pmem_write_d   = 1'b0;
                        state_d        = SERVE_I;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = grant;
`endif
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    i_rdata_d    = pmem_rdata;
                    i_resp_d     = 1'b1;
                    state_d      = RESP;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    d_rdata_d    = pmem_rdata;
                    d_resp_d     = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                // owner drops its request at this edge, so nothing is re-granted
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign i_pmem_resp  = i_resp_q;
    assign d_pmem_resp  = d_resp_q;
    assign i_pmem_rdata = i_rdata_q;
    assign d_pmem_rdata = d_rdata_q;

    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(d_pmem_read && d_pmem_write));

endmodule

// File: tb/tb_cache_pmem_arbiter.sv
// tb/tb_cache_pmem_arbiter.sv - self-checking bench for cache_pmem_arbiter
module tb_cache_pmem_arbiter;
    import arb_pkg::*;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic          i_pmem_resp;
    logic [LW-1:0] i_pmem_rdata;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic          d_pmem_resp;
    logic [LW-1:0] d_pmem_rdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp = 1'b0;
    logic [LW-1:0] pmem_rdata = '0;

    cache_pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b required %0b", name, act, exp);
        end
    endtask

    task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // reference model: spec-level view of who owns the port and what each client holds
    bit            last_was_d;
    bit            own_d;
    logic          prev_strobe, prev_i_resp, prev_d_resp;
    logic [AW-1:0] prev_addr;
    logic [LW-1:0] prev_wdata;
    logic [LW-1:0] exp_i_rdata, exp_d_rdata, resp_rdata;
    int            i_wait, d_wait;
    bit            grants[$];
    int            i_resps, d_resps, i_issued, d_issued, rd_cycles, wr_cycles;

    // client and memory stimulus controls
    int            i_rate = 0, d_rate = 0;
    bit            i_go = 0, d_go = 0, d_next_write = 0;
    logic [AW-1:0] i_next_addr = '0, d_next_addr = '0;
    logic [LW-1:0] d_next_wdata = '0;
    int            mem_cnt = 0, mem_lat = 1, fix_lat = 0;
    bit            spurious = 0, vec_mode = 0;
    logic [LW-1:0] vec_rdata = '0;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] w;
        for (int k = 0; k < LW / 32; k++) w[k*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic reset_model();
        last_was_d = 0; own_d = 0;
        prev_strobe = 0; prev_i_resp = 0; prev_d_resp = 0;
        prev_addr = '0; prev_wdata = '0;
        exp_i_rdata = '0; exp_d_rdata = '0; resp_rdata = '0;
        i_wait = 0; d_wait = 0; grants.delete();
        i_resps = 0; d_resps = 0; i_issued = 0; d_issued = 0;
        rd_cycles = 0; wr_cycles = 0; mem_cnt = 0;
    endtask

    // One clock: sample what the DUT saw at the edge, check outputs just after it,
    // then update clients and the memory responder.
    task automatic cycle();
        logic          s_i, s_d, s_dw, s_resp, strobe, exp_ir, exp_dr;
        logic [AW-1:0] s_ia, s_da, a;
        logic [LW-1:0] s_wd;
        bit            win_d, w;
        @(posedge clk);
        s_i = i_pmem_read; s_d = d_pmem_read | d_pmem_write; s_dw = d_pmem_write;
        s_ia = i_pmem_address; s_da = d_pmem_address; s_wd = d_pmem_wdata;
        s_resp = pmem_resp;
        #1;
        strobe = pmem_read | pmem_write;
        chk1("one_strobe", pmem_read & pmem_write, 1'b0);
        if (prev_strobe && strobe) begin
            chka("addr_stable", pmem_address, prev_addr);
            chkw("wdata_stable", pmem_wdata, prev_wdata);
        end
        if (prev_strobe) chk1("strobe_held_until_resp", ~strobe, s_resp);
        chk1("i_resp_not_twice", i_pmem_resp & prev_i_resp, 1'b0);
        chk1("d_resp_not_twice", d_pmem_resp & prev_d_resp, 1'b0);
        exp_ir = prev_strobe & ~strobe & ~own_d;
        exp_dr = prev_strobe & ~strobe & own_d;
        chk1("i_resp", i_pmem_resp, exp_ir);
        chk1("d_resp", d_pmem_resp, exp_dr);
        if (exp_ir) exp_i_rdata = resp_rdata;
        if (exp_dr) exp_d_rdata = resp_rdata;
        chkw("i_rdata", i_pmem_rdata, exp_i_rdata);
        chkw("d_rdata", d_pmem_rdata, exp_d_rdata);
        i_resps += int'(i_pmem_resp);
        d_resps += int'(d_pmem_resp);
        if (strobe && !prev_strobe) begin
            chk1("grant_needs_request", s_i | s_d, 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
            win_d = s_d && !(s_i && last_was_d);
`else
            win_d = s_d;
`endif
            chka("grant_addr", pmem_address, win_d ? s_da : s_ia);
            chk1("grant_read", pmem_read, !win_d || !s_dw);
            chk1("grant_write", pmem_write, win_d && s_dw);
            if (win_d && s_dw) chkw("grant_wdata", pmem_wdata, s_wd);
            if (win_d) begin
                d_wait = 0;
                if (s_i) i_wait++;
            end else begin
                i_wait = 0;
                if (s_d) d_wait++;
            end
`ifdef ARB_ROUND_ROBIN_EN
            chk1("rr_no_starvation", (i_wait <= 1) && (d_wait <= 1), 1'b1);
`endif
            own_d = win_d; last_was_d = win_d;
            grants.push_back(win_d);
        end
        rd_cycles += int'(pmem_read);
        wr_cycles += int'(pmem_write);
        prev_strobe = strobe; prev_addr = pmem_address; prev_wdata = pmem_wdata;
        prev_i_resp = i_pmem_resp; prev_d_resp = d_pmem_resp;

        // I-cache client: hold until resp, then drop for at least one edge
        if (i_pmem_read && i_pmem_resp) begin
            i_pmem_read = 1'b0;
        end else if (!i_pmem_read && (i_go || int'($urandom_range(99)) < i_rate)) begin
            a = i_go ? i_next_addr : ($urandom() & 32'hFFFF_FFE0);
            i_pmem_address = a; i_pmem_read = 1'b1; i_go = 0; i_issued++;
        end
        // D-cache client
        if ((d_pmem_read || d_pmem_write) && d_pmem_resp) begin
            d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        end else if (!(d_pmem_read || d_pmem_write) && (d_go || int'($urandom_range(99)) < d_rate)) begin
            if (d_go) begin
                a = d_next_addr; w = d_next_write; d_pmem_wdata = d_next_wdata;
            end else begin
                a = $urandom() & 32'hFFFF_FFE0; w = $urandom_range(1); d_pmem_wdata = rand_line();
            end
            d_pmem_address = a; d_pmem_write = w; d_pmem_read = !w; d_go = 0; d_issued++;
        end
        // memory: answer a strobe after mem_lat cycles of it being visible
        if (strobe) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                resp_rdata = vec_mode ? vec_rdata : rand_line();
                pmem_resp = 1'b1; pmem_rdata = resp_rdata;
            end else begin
                pmem_resp = 1'b0; pmem_rdata = rand_line();
            end
        end else begin
            mem_cnt = 0;
            mem_lat = (fix_lat > 0) ? fix_lat : int'($urandom_range(5, 1));
            pmem_resp = spurious && ($urandom_range(3) == 0);
            pmem_rdata = rand_line();
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((i_pmem_read || d_pmem_read || d_pmem_write || i_go || d_go ||
                pmem_read || pmem_write || i_pmem_resp || d_pmem_resp) && n < budget) begin
            cycle();
            n++;
        end
        chk1(name, n < budget, 1'b1);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; pmem_resp = 0;
        i_go = 0; d_go = 0; i_rate = 0; d_rate = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        reset_model();
    endtask

    typedef struct {
        bit            is_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        int            lat;
        logic [LW-1:0] rdata;
        int            exp_rd;
        int            exp_wr;
        int            exp_ir;
        int            exp_dr;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lead;
        bit seen_i;
        vecs[0] = '{0, 0, 32'h0000_0060, '0, 3, {32{8'hA5}}, 3, 0, 1, 0};
        vecs[1] = '{1, 1, 32'h0000_1000, {8{32'h1234_5678}}, 2, {8{32'hDEAD_BEEF}}, 0, 2, 0, 1};
        vecs[2] = '{1, 0, 32'h0000_2FE0, '0, 1, {8{32'h0F0F_1E1E}}, 1, 0, 0, 1};
        vecs[3] = '{0, 0, 32'hFFFF_FFE0, '0, 5, {8{32'h7777_0001}}, 5, 0, 1, 0};

        reset_model();
        #1 rst = 1'b1;
        #1;
        chk1("rst_pmem_read", pmem_read, 1'b0);
        chk1("rst_pmem_write", pmem_write, 1'b0);
        chka("rst_pmem_address", pmem_address, '0);
        chkw("rst_pmem_wdata", pmem_wdata, '0);
        chk1("rst_i_resp", i_pmem_resp, 1'b0);
        chk1("rst_d_resp", d_pmem_resp, 1'b0);
        chkw("rst_i_rdata", i_pmem_rdata, '0);
        chkw("rst_d_rdata", d_pmem_rdata, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // single-client transactions from the vector table
        vec_mode = 1;
        for (int v = 0; v < 4; v++) begin
            fix_lat = vecs[v].lat; vec_rdata = vecs[v].rdata;
            cycle();
            rd_cycles = 0; wr_cycles = 0; i_resps = 0; d_resps = 0;
            if (vecs[v].is_d) begin
                d_next_addr = vecs[v].addr; d_next_write = vecs[v].wr;
                d_next_wdata = vecs[v].wdata; d_go = 1;
            end else begin
                i_next_addr = vecs[v].addr; i_go = 1;
            end
            wait_idle(60, "vec_timeout");
            chki("vec_read_cycles", rd_cycles, vecs[v].exp_rd);
            chki("vec_write_cycles", wr_cycles, vecs[v].exp_wr);
            chki("vec_i_resps", i_resps, vecs[v].exp_ir);
            chki("vec_d_resps", d_resps, vecs[v].exp_dr);
            chkw("vec_rdata", vecs[v].is_d ? d_pmem_rdata : i_pmem_rdata, vecs[v].rdata);
        end
        vec_mode = 0;

        // simultaneous I read 0x40 and D read 0x80 right after reset: D first, then I
        apply_reset();
        fix_lat = 2;
        i_next_addr = 32'h40; d_next_addr = 32'h80; d_next_write = 0;
        i_go = 1; d_go = 1;
        wait_idle(60, "simul_timeout");
        chki("simul_grant_count", grants.size(), 2);
        if (grants.size() == 2) begin
            chk1("simul_first_is_d", grants[0], 1'b1);
            chk1("simul_second_is_i", grants[1], 1'b0);
        end
        chki("simul_i_resps", i_resps, 1);
        chki("simul_d_resps", d_resps, 1);

        // continuous D traffic with one pending I request
        apply_reset();
        fix_lat = 2;
        i_next_addr = 32'h0000_0500; i_go = 1; d_rate = 100;
        repeat (40) cycle();
        lead = 0; seen_i = 0;
        foreach (grants[k]) begin
            if (!seen_i) begin
                if (grants[k]) lead++;
                else seen_i = 1;
            end
        end
`ifdef ARB_ROUND_ROBIN_EN
        chk1("rr_i_after_one_d", lead <= 1, 1'b1);
        chki("rr_i_served", i_resps, 1);
`else
        chki("fixed_i_starved", i_resps, 0);
        chk1("fixed_d_kept_port", lead >= 3, 1'b1);
`endif
        d_rate = 0;
        wait_idle(80, "cont_timeout");
        chki("cont_i_done", i_resps, 1);

        // reset in the middle of a D read
        fix_lat = 20; d_next_addr = 32'h0000_0300; d_next_write = 0; d_go = 1;
        repeat (4) cycle();
        chk1("mid_serve_strobe", pmem_read, 1'b1);
        #3 rst = 1'b1;
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; pmem_resp = 0; d_go = 0;
        #1;
        chk1("async_pmem_read", pmem_read, 1'b0);
        chk1("async_pmem_write", pmem_write, 1'b0);
        chka("async_pmem_address", pmem_address, '0);
        chkw("async_pmem_wdata", pmem_wdata, '0);
        chk1("async_i_resp", i_pmem_resp, 1'b0);
        chk1("async_d_resp", d_pmem_resp, 1'b0);
        chkw("async_i_rdata", i_pmem_rdata, '0);
        chkw("async_d_rdata", d_pmem_rdata, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        reset_model();
        fix_lat = 2;
        repeat (8) cycle();
        chki("post_rst_no_stale_resp", d_resps + i_resps, 0);
        i_next_addr = 32'h0000_0A00; i_go = 1;
        wait_idle(40, "post_rst_timeout");
        chki("post_rst_i_served", i_resps, 1);

        // randomized traffic with random latency and stray pmem_resp outside service
        apply_reset();
        fix_lat = 0; spurious = 1; i_rate = 30; d_rate = 30;
        repeat (1500) cycle();
        i_rate = 0; d_rate = 0;
        wait_idle(100, "rand_timeout");
        spurious = 0;
        chki("rand_i_one_resp_each", i_resps, i_issued);
        chki("rand_d_one_resp_each", d_resps, d_issued);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
